// File: rtl/trace_skew_cmp.sv
// Lockstep comparator for two redundant trace streams. The leading stream is
// buffered in a small FIFO so the streams may drift up to DEPTH entries apart.
module trace_skew_cmp #(
   parameter int DATA_W = 36,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 16
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       valid_a,
   input  logic [DATA_W-1:0]          data_a,
   input  logic                       valid_b,
   input  logic [DATA_W-1:0]          data_b,
   input  logic [DATA_W-1:0]          cmp_mask,
   input  logic                       clear,
   output logic                       mismatch,
   output logic                       err,
   output logic [DATA_W-1:0]          err_data_a,
   output logic [DATA_W-1:0]          err_data_b,
   output logic                       overflow,
   output logic [CNT_W-1:0]           match_count,
   output logic [$clog2(DEPTH):0]     skew,
   output logic                       lead_b
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int SKW_W = PTR_W + 1;
   localparam logic [SKW_W-1:0] FULL = SKW_W'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];

   logic [PTR_W-1:0]  head_reg, tail_reg;
   logic [SKW_W-1:0]  count_reg, count_next;
   logic              lead_b_reg, lead_b_next;
   logic              mismatch_reg, err_reg, overflow_reg;
   logic [DATA_W-1:0] err_data_a_reg, err_data_b_reg;
   logic [CNT_W-1:0]  match_count_reg;

   logic              push, pop, do_cmp, ovf_set, equal;
   logic [DATA_W-1:0] push_word, op_a, op_b, head_word;
   logic              lead_v, trail_v;
   logic [DATA_W-1:0] lead_word;

   assign head_word = mem[head_reg];
   assign lead_v    = lead_b_reg ? valid_b : valid_a;
   assign trail_v   = lead_b_reg ? valid_a : valid_b;
   assign lead_word = lead_b_reg ? data_b : data_a;
   assign equal     = ((op_a ^ op_b) & cmp_mask) == '0;

   always_comb begin
      push        = 1'b0;
      pop         = 1'b0;
      do_cmp      = 1'b0;
      ovf_set     = 1'b0;
      push_word   = lead_word;
      lead_b_next = lead_b_reg;
      op_a        = data_a;
      op_b        = data_b;
      if (!clear) begin
         if (count_reg == '0) begin
            if (valid_a && valid_b) begin
               do_cmp = 1'b1;
            end else if (valid_a) begin
               push        = 1'b1;
               push_word   = data_a;
               lead_b_next = 1'b0;
            end else if (valid_b) begin
               push        = 1'b1;
               push_word   = data_b;
               lead_b_next = 1'b1;
            end
         end else begin
            // The buffered head always belongs to the leading stream.
            if (lead_b_reg) op_b = head_word;
            else            op_a = head_word;
            if (trail_v) begin
               pop    = 1'b1;
               do_cmp = 1'b1;
               push   = lead_v;
            end else if (lead_v) begin
               if (count_reg < FULL) push    = 1'b1;
               else                  ovf_set = 1'b1;
            end
         end
      end
   end

   always_comb begin
      count_next = count_reg;
      if (push && !pop)      count_next = count_reg + SKW_W'(1);
      else if (pop && !push) count_next = count_reg - SKW_W'(1);
   end

   always_ff @(posedge clk) begin
      if (push) mem[tail_reg] <= push_word;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head_reg        <= '0;
         tail_reg        <= '0;
         count_reg       <= '0;
         lead_b_reg      <= 1'b0;
         mismatch_reg    <= 1'b0;
         err_reg         <= 1'b0;
         overflow_reg    <= 1'b0;
         err_data_a_reg  <= '0;
         err_data_b_reg  <= '0;
         match_count_reg <= '0;
      end else if (clear) begin
         head_reg        <= '0;
         tail_reg        <= '0;
         count_reg       <= '0;
         lead_b_reg      <= 1'b0;
         mismatch_reg    <= 1'b0;
         err_reg         <= 1'b0;
         overflow_reg    <= 1'b0;
         err_data_a_reg  <= '0;
         err_data_b_reg  <= '0;
         match_count_reg <= '0;
      end else begin
         if (push) tail_reg <= tail_reg + PTR_W'(1);
         if (pop)  head_reg <= head_reg + PTR_W'(1);
         count_reg    <= count_next;
         lead_b_reg   <= lead_b_next;
         mismatch_reg <= do_cmp && !equal;
         if (ovf_set) overflow_reg <= 1'b1;
         if (do_cmp && equal && match_count_reg != '1)
            match_count_reg <= match_count_reg + CNT_W'(1);
         if (do_cmp && !equal) begin
            err_reg <= 1'b1;
            if (!err_reg) begin
               err_data_a_reg <= op_a;
               err_data_b_reg <= op_b;
            end
         end
      end
   end

   assign mismatch    = mismatch_reg;
   assign err         = err_reg;
   assign err_data_a  = err_data_a_reg;
   assign err_data_b  = err_data_b_reg;
   assign overflow    = overflow_reg;
   assign match_count = match_count_reg;
   assign skew        = count_reg;
   assign lead_b      = lead_b_reg;

endmodule
